// File: rtl/arb_bus_pkg.sv
// arb_bus_pkg: shared types and grant encodings for the grant-driven bus controller
package arb_bus_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE, WAIT_REL} state_t;
  typedef logic owner_t;
  localparam logic [1:0] GRANT0 = 2'b01;
  localparam logic [1:0] GRANT1 = 2'b10;
endpackage

// File: rtl/arb_bus_timeout.sv
// arb_bus_timeout: saturating wait counter flagging expiry at TIMEOUT-1
module arb_bus_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != 8'hff) cnt <= cnt + 8'd1;
  assign expired = cnt == 8'(TIMEOUT - 1);
endmodule

// File: rtl/arb_grant_bus_ctrl.sv
// arb_grant_bus_ctrl: runs one shared-bus transaction per arbiter grant and
// reports completion (or timeout) back to the owning requester
module arb_grant_bus_ctrl
  import arb_bus_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        grant,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  input  logic              req_we0,
  input  logic              req_we1,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              grant_err,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata
);
  state_t state;
  owner_t owner;
  logic   expired;
  arb_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != REQ),
    .en      (state == REQ && !bus_ready),
    .expired (expired)
  );
  // bus_valid decodes the state flop directly so an async reset drops it at once
  assign bus_valid = state == REQ;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      done      <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      grant_err <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE:
          if (grant == GRANT0 || grant == GRANT1) begin
            owner     <= grant[1];
            bus_addr  <= grant[1] ? req_addr1 : req_addr0;
            bus_wdata <= grant[1] ? req_wdata1 : req_wdata0;
            bus_we    <= grant[1] ? req_we1 : req_we0;
            state     <= REQ;
          end else if (grant == 2'b11) grant_err <= 1'b1;
        REQ:
          if (bus_ready || expired) begin
            done  <= owner ? GRANT1 : GRANT0;
            rdata <= bus_ready ? bus_rdata : '0;
            err   <= !bus_ready;
            state <= DONE;
          end
        DONE:     state <= WAIT_REL;
        WAIT_REL: state <= grant[owner] ? WAIT_REL : IDLE;
        default:  state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_arb_grant_bus_ctrl.sv
// tb_arb_grant_bus_ctrl: directed self-checking bench for arb_grant_bus_ctrl
module tb_arb_grant_bus_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] grant = '0;
  logic [7:0] req_addr0 = '0, req_addr1 = '0, req_wdata0 = '0, req_wdata1 = '0;
  logic       req_we0 = 1'b0, req_we1 = 1'b0;
  logic [1:0] done;
  logic [7:0] rdata, bus_addr, bus_wdata;
  logic       err, grant_err, bus_valid, bus_we;
  logic       bus_ready = 1'b0;
  logic [7:0] bus_rdata = '0;
  int n_checks = 0;
  int n_errors = 0;
  arb_grant_bus_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .grant      (grant),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .req_we0    (req_we0),
    .req_we1    (req_we1),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .grant_err  (grant_err),
    .bus_valid  (bus_valid),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int cnt;
    repeat (7) step();
    check("rst valid", 32'(bus_valid), 0);
    check("rst done", 32'(done), 0);
    check("rst err", 32'(err), 0);
    check("rst gerr", 32'(grant_err), 0);
    check("rst rdata", 32'(rdata), 0);
    check("rst addr", 32'(bus_addr), 0);
    rst = 1'b1;
    step();
    // 1: immediate-ready read; bus_ready already high while idle must be ignored
    grant = 2'b01; req_addr0 = 8'h3C; req_we0 = 1'b0; bus_ready = 1'b1; bus_rdata = 8'hA5;
    check("t1 idle valid", 32'(bus_valid), 0);
    step();
    check("t1 valid", 32'(bus_valid), 1);
    check("t1 addr", 32'(bus_addr), 32'h3C);
    check("t1 we", 32'(bus_we), 0);
    step();
    check("t1 done", 32'(done), 1);
    check("t1 rdata", 32'(rdata), 32'hA5);
    check("t1 err", 32'(err), 0);
    check("t1 valid off", 32'(bus_valid), 0);
    grant = 2'b00; bus_ready = 1'b0;
    step();
    check("t1 done pulse", 32'(done), 0);
    step();
    // 2: write, slave ready in 4th valid cycle; requester inputs change mid-REQ
    grant = 2'b10; req_addr1 = 8'h10; req_wdata1 = 8'h55; req_we1 = 1'b1;
    step();
    req_wdata1 = 8'hFF; req_addr1 = 8'hEE; req_we1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2 valid", 32'(bus_valid), 1);
      check("t2 we", 32'(bus_we), 1);
      check("t2 wdata", 32'(bus_wdata), 32'h55);
      check("t2 addr", 32'(bus_addr), 32'h10);
      if (i == 3) begin bus_ready = 1'b1; bus_rdata = 8'h77; end
      step();
    end
    check("t2 done", 32'(done), 2);
    check("t2 rdata", 32'(rdata), 32'h77);
    check("t2 err", 32'(err), 0);
    grant = 2'b00; bus_ready = 1'b0;
    step(); step();
    // 3: timeout
    grant = 2'b01; bus_rdata = 8'hEE;
    step();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus_valid) break;
      cnt++;
      step();
    end
    check("t3 valid cycles", 32'(cnt), 16);
    check("t3 done", 32'(done), 1);
    check("t3 err", 32'(err), 1);
    check("t3 rdata", 32'(rdata), 0);
    grant = 2'b00;
    step();
    check("t3 err pulse", 32'(err), 0);
    step();
    // 4: illegal double grant, then a normal grant
    grant = 2'b11;
    step();
    check("t4 gerr", 32'(grant_err), 1);
    check("t4 no valid", 32'(bus_valid), 0);
    step();
    check("t4 gerr sticky", 32'(grant_err), 1);
    check("t4 no valid2", 32'(bus_valid), 0);
    grant = 2'b01; bus_ready = 1'b1; bus_rdata = 8'h3E;
    step();
    check("t4 valid", 32'(bus_valid), 1);
    step();
    check("t4 done", 32'(done), 1);
    check("t4 rdata", 32'(rdata), 32'h3E);
    check("t4 gerr held", 32'(grant_err), 1);
    // 5: grant held after done, then direct switch 01 -> 10
    bus_ready = 1'b0;
    step();
    check("t5 held valid", 32'(bus_valid), 0);
    check("t5 held done", 32'(done), 0);
    step();
    check("t5 held valid2", 32'(bus_valid), 0);
    grant = 2'b10; req_addr1 = 8'h20; bus_ready = 1'b1; bus_rdata = 8'h99;
    step();
    check("t5 release gap", 32'(bus_valid), 0);
    step();
    check("t5 valid", 32'(bus_valid), 1);
    check("t5 addr", 32'(bus_addr), 32'h20);
    step();
    check("t5 done", 32'(done), 2);
    check("t5 rdata", 32'(rdata), 32'h99);
    grant = 2'b00; bus_ready = 1'b0;
    step(); step();
    // 6: async reset during REQ
    grant = 2'b01;
    step();
    check("t6 valid", 32'(bus_valid), 1);
    #2 rst = 1'b0;
    #1;
    check("t6 async drop", 32'(bus_valid), 0);
    check("t6 no done", 32'(done), 0);
    step();
    check("t6 no done2", 32'(done), 0);
    check("t6 gerr cleared", 32'(grant_err), 0);
    grant = 2'b00;
    rst = 1'b1;
    step();
    check("t6 idle", 32'(bus_valid), 0);
    grant = 2'b01; req_addr0 = 8'h42; bus_ready = 1'b1; bus_rdata = 8'h5A;
    step();
    check("t6 fresh valid", 32'(bus_valid), 1);
    check("t6 fresh addr", 32'(bus_addr), 32'h42);
    step();
    check("t6 fresh done", 32'(done), 1);
    check("t6 fresh rdata", 32'(rdata), 32'h5A);
    check("t6 fresh err", 32'(err), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/arb_grant_bus_ctrl.md
Name: arb_grant_bus_ctrl

Overview:
- Downstream consumer of the 2-requester arbiter's one-hot `grant`.
- Latches the command (addr/wdata/we) of the granted requester and runs one transaction on a single shared slave bus using a valid/ready handshake.
- Returns a per-requester `done` pulse with read data, or an error on timeout.
- Waits for the arbiter to drop the grant before accepting the next owner.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- TIMEOUT, 16, maximum REQ cycles without `bus_ready` before aborting (legal range 2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- grant  input  2  one-hot grant from the arbiter; 2'b01 = requester 0, 2'b10 = requester 1.
- req_addr0, req_addr1  input  ADDR_W  per-requester address.
- req_wdata0, req_wdata1  input  DATA_W  per-requester write data.
- req_we0, req_we1  input  1  per-requester write enable; 1 = write, 0 = read.
- done  output  2  one-cycle completion pulse on bit [owner].
- rdata  output  DATA_W  read data; valid while `done` != 0.
- err  output  1  timeout flag; pulses together with `done`.
- grant_err  output  1  sticky flag; set when grant == 2'b11 is sampled; cleared only by reset.
- bus_valid  output  1  request valid on the shared bus.
- bus_addr  output  ADDR_W  bus address.
- bus_wdata  output  DATA_W  bus write data.
- bus_we  output  1  bus write enable.
- bus_ready  input  1  slave accept/complete.
- bus_rdata  input  DATA_W  slave read data; sampled when `bus_valid && bus_ready`.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; owner 0; timeout counter 0.
- FSM states: IDLE, REQ, DONE, WAIT_REL.
- IDLE:
  - grant == 2'b01 or 2'b10 at a clk edge: latch owner and that requester's addr/wdata/we; go to REQ.
  - grant == 2'b11: set grant_err, stay IDLE.
  - grant == 2'b00: stay IDLE.
- REQ:
  - bus_valid = 1; bus_addr/bus_wdata/bus_we driven from the latched registers and held stable.
  - bus_ready = 1: capture bus_rdata (capture on writes too); go to DONE with err_next = 0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ready: go to DONE with err_next = 1 and rdata = 0.
  - Counter clears on entry to REQ.
- DONE:
  - done[owner] = 1 for exactly one cycle; rdata and err valid in that cycle.
  - bus_valid = 0.
  - Go to WAIT_REL.
- WAIT_REL: stay until grant[owner] == 0, then IDLE. The next grant is accepted no earlier than the following cycle.
- Latency with an immediately ready slave:
  - grant sampled at edge N;
  - bus_valid high during cycle N+1;
  - done high during cycle N+2.
- Boundary conditions:
  - Grant withdrawn during REQ: the transaction completes; done still pulses, because the bus cannot abort.
  - Grant switches directly 01 -> 10 while in WAIT_REL: treated as release of owner 0. IDLE then samples 10 the next cycle.
  - Requester inputs changing during REQ: ignored; only the latched values are used.
  - bus_ready high while bus_valid == 0: ignored.
  - Reset asserted mid-REQ: bus_valid drops immediately (asynchronously); no done pulse.
- Outputs are registered; no combinational path from grant to bus_*.

Decomposition:
- Package arb_bus_pkg:
  - typedef enum logic [1:0] state_t {IDLE, REQ, DONE, WAIT_REL};
  - typedef logic owner_t;
  - localparams GRANT0 = 2'b01, GRANT1 = 2'b10.
- Sub-module arb_bus_timeout:
  - saturating counter with clear/enable inputs;
  - `expired` output at TIMEOUT-1.

Test Plan:
1. Reset low 7 cycles, then high; grant = 01 with addr0 = 8'h3C, we0 = 0, slave returns ready + bus_rdata = 8'hA5 in its first valid cycle -> bus_valid high 1 cycle with bus_addr = 8'h3C; done = 2'b01 the next cycle; rdata = 8'hA5; err = 0.
2. grant = 10 with addr1 = 8'h10, wdata1 = 8'h55, we1 = 1, slave ready after 3 cycles -> bus_valid high 4 cycles with bus_we = 1 and bus_wdata = 8'h55; then done = 2'b10.
3. grant = 01, bus_ready never asserted, TIMEOUT = 16 -> bus_valid high exactly 16 cycles; then done = 01 with err = 1 and rdata = 0.
4. grant = 11 -> grant_err = 1 and stays 1; no bus_valid; a later grant = 01 still completes normally.
5. grant = 01 held after done, then switched to 10 -> no second transaction for owner 0; owner 1's transaction starts one cycle after the release is seen.
6. rst pulled low during REQ -> bus_valid drops immediately; done = 00; after reset goes high, state is IDLE and a fresh grant is served normally.
